// File: rtl/picoblaze_io_pkg.sv
// Shared constants for the pacoblaze3 I/O bridge: port map, status bit layout
// and the interrupt request state type.
package picoblaze_io_pkg;

    localparam logic [7:0] PORT_IN_BASE  = 8'h00;
    localparam logic [7:0] PORT_STATUS   = 8'h08;
    localparam logic [7:0] PORT_OVR_CNT  = 8'h09;
    localparam logic [7:0] PORT_OUT_BASE = 8'h80;
    localparam logic [7:0] PORT_DONE     = 8'h40;
    localparam logic [7:0] PORT_INT_CTRL = 8'h41;

    localparam int STAT_START_BIT   = 0;
    localparam int STAT_OVERRUN_BIT = 1;
    localparam int STAT_INT_EN_BIT  = 2;

    typedef enum logic [0:0] {
        IRQ_IDLE = 1'b0,
        IRQ_PEND = 1'b1
    } irq_state_e;

    function automatic logic [7:0] pack_status(input logic start_flag,
                                               input logic overrun,
                                               input logic int_en);
        logic [7:0] st;
        st                   = 8'h00;
        st[STAT_START_BIT]   = start_flag;
        st[STAT_OVERRUN_BIT] = overrun;
        st[STAT_INT_EN_BIT]  = int_en;
        return st;
    endfunction

endpackage

// File: rtl/picoblaze_int_timer.sv
// Periodic interrupt generator with request/acknowledge handshake and overrun flag.
// Define INT_OVERRUN_COUNT_EN to add the 8-bit saturating overrun counter.
module picoblaze_int_timer
    import picoblaze_io_pkg::*;
#(
    parameter int INT_PERIOD = 7200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       int_en_i,
    input  logic       int_ack_i,
    input  logic       ovr_clr_i,
`ifdef INT_OVERRUN_COUNT_EN
    input  logic       cnt_clr_i,
    output logic [7:0] ovr_cnt_o,
`endif
    output logic       irq_o,
    output logic       overrun_o
);

    localparam int CW = $clog2(INT_PERIOD);
    localparam logic [CW-1:0] TERM = CW'(INT_PERIOD - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    irq_state_e    irq_state_q, irq_state_d;
    logic          overrun_q, overrun_d;
    logic          tick_s;
    logic          ovr_set_s;

    // Period counter plus interrupt handshake; a tick always wins over an ack.
    always_comb begin
        tick_s      = int_en_i && (cnt_q == TERM);
        cnt_d       = cnt_q;
        irq_state_d = irq_state_q;
        ovr_set_s   = 1'b0;

        if (!int_en_i) begin
            cnt_d = {CW{1'b0}};
        end else if (tick_s) begin
            cnt_d = {CW{1'b0}};
        end else begin
            cnt_d = cnt_q + CW'(1);
        end

        case (irq_state_q)
            IRQ_IDLE: begin
                if (tick_s) begin
                    irq_state_d = IRQ_PEND;
                end else begin
                    irq_state_d = IRQ_IDLE;
                end
            end
            IRQ_PEND: begin
                if (tick_s) begin
                    irq_state_d = IRQ_PEND;
                    ovr_set_s   = !int_ack_i;
                end else if (int_ack_i) begin
                    irq_state_d = IRQ_IDLE;
                end else begin
                    irq_state_d = IRQ_PEND;
                end
            end
            default: irq_state_d = IRQ_IDLE;
        endcase

        if (ovr_set_s) begin
            overrun_d = 1'b1;
        end else if (ovr_clr_i) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    // State registers for the counter, request and overrun flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= {CW{1'b0}};
            irq_state_q <= IRQ_IDLE;
            overrun_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            irq_state_q <= irq_state_d;
            overrun_q   <= overrun_d;
        end
    end

    assign irq_o     = (irq_state_q == IRQ_PEND);
    assign overrun_o = overrun_q;

`ifdef INT_OVERRUN_COUNT_EN
    logic [7:0] ovr_cnt_q, ovr_cnt_d;
    logic [7:0] ovr_cnt_base_s;

    // A clear and an overrun in the same cycle leave a count of one.
    always_comb begin
        ovr_cnt_base_s = cnt_clr_i ? 8'h00 : ovr_cnt_q;
        if (ovr_set_s && (ovr_cnt_base_s != 8'hFF)) begin
            ovr_cnt_d = ovr_cnt_base_s + 8'h01;
        end else begin
            ovr_cnt_d = ovr_cnt_base_s;
        end
    end

    // Overrun counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovr_cnt_q <= 8'h00;
        end else begin
            ovr_cnt_q <= ovr_cnt_d;
        end
    end

    assign ovr_cnt_o = ovr_cnt_q;
`endif

endmodule

// File: rtl/picoblaze_io_bridge.sv
// I/O bridge between a pacoblaze3 core and the speech-synthesizer fabric.
// Define INT_OVERRUN_COUNT_EN to make the overrun counter readable at PORT_OVR_CNT.
module picoblaze_io_bridge
    import picoblaze_io_pkg::*;
#(
    parameter int NUM_IN     = 4,
    parameter int NUM_OUT    = 4,
    parameter int INT_PERIOD = 7200
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           port_id,
    input  logic [7:0]           out_port,
    input  logic                 write_strobe,
    input  logic                 read_strobe,
    output logic [7:0]           in_port,
    output logic                 interrupt,
    input  logic                 interrupt_ack,
    input  logic [NUM_IN*8-1:0]  in_data,
    input  logic                 start_pico,
    output logic [NUM_OUT*8-1:0] out_data,
    output logic [NUM_OUT-1:0]   out_wr_stb,
    output logic                 pico_done
);

    logic [7:0]           in_port_q, in_port_d;
    logic [NUM_OUT*8-1:0] out_data_q, out_data_d;
    logic [NUM_OUT-1:0]   out_wr_stb_q, wr_hit_s;
    logic                 pico_done_q, pico_done_d;
    logic                 int_en_q, int_en_d;
    logic                 start_sync_q, start_prev_q;
    logic                 start_flag_q, start_flag_d;
    logic                 rd_status_s, rd_ovr_cnt_s;
    logic                 int_overrun_s;
    logic [7:0]           ovr_cnt_s;

    assign rd_status_s  = read_strobe && (port_id == PORT_STATUS);
    assign rd_ovr_cnt_s = read_strobe && (port_id == PORT_OVR_CNT);

    picoblaze_int_timer #(
        .INT_PERIOD (INT_PERIOD)
    ) u_int_timer (
        .clk       (clk),
        .reset     (reset),
        .int_en_i  (int_en_q),
        .int_ack_i (interrupt_ack),
        .ovr_clr_i (rd_status_s),
`ifdef INT_OVERRUN_COUNT_EN
        .cnt_clr_i (rd_ovr_cnt_s),
        .ovr_cnt_o (ovr_cnt_s),
`endif
        .irq_o     (interrupt),
        .overrun_o (int_overrun_s)
    );

`ifndef INT_OVERRUN_COUNT_EN
    assign ovr_cnt_s = 8'h00;
`endif

    // Read mux; unmapped addresses fall through to 0x00.
    always_comb begin
        in_port_d = 8'h00;
        case (port_id)
            PORT_STATUS:  in_port_d = pack_status(start_flag_q, int_overrun_s, int_en_q);
            PORT_OVR_CNT: in_port_d = rd_ovr_cnt_s ? ovr_cnt_s : ovr_cnt_s;
            default: begin
                for (int i = 0; i < NUM_IN; i++) begin
                    in_port_d = (port_id == (PORT_IN_BASE + 8'(i))) ? in_data[i*8 +: 8] : in_port_d;
                end
            end
        endcase
    end

    // Write decode for output channels, done pulse, interrupt enable and start flag.
    always_comb begin
        out_data_d = out_data_q;
        for (int i = 0; i < NUM_OUT; i++) begin
            wr_hit_s[i]          = write_strobe && (port_id == (PORT_OUT_BASE + 8'(i)));
            out_data_d[i*8 +: 8] = wr_hit_s[i] ? out_port : out_data_q[i*8 +: 8];
        end
        pico_done_d = write_strobe && (port_id == PORT_DONE) && out_port[0];
        int_en_d    = (write_strobe && (port_id == PORT_INT_CTRL)) ? out_port[0] : int_en_q;

        if (start_sync_q && !start_prev_q) begin
            start_flag_d = 1'b1;
        end else if (rd_status_s) begin
            start_flag_d = 1'b0;
        end else begin
            start_flag_d = start_flag_q;
        end
    end

    // Bridge registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_port_q    <= 8'h00;
            out_data_q   <= {(NUM_OUT*8){1'b0}};
            out_wr_stb_q <= {NUM_OUT{1'b0}};
            pico_done_q  <= 1'b0;
            int_en_q     <= 1'b0;
            start_sync_q <= 1'b0;
            start_prev_q <= 1'b0;
            start_flag_q <= 1'b0;
        end else begin
            in_port_q    <= in_port_d;
            out_data_q   <= out_data_d;
            out_wr_stb_q <= wr_hit_s;
            pico_done_q  <= pico_done_d;
            int_en_q     <= int_en_d;
            start_sync_q <= start_pico;
            start_prev_q <= start_sync_q;
            start_flag_q <= start_flag_d;
        end
    end

    assign in_port    = in_port_q;
    assign out_data   = out_data_q;
    assign out_wr_stb = out_wr_stb_q;
    assign pico_done  = pico_done_q;

endmodule

// File: tb/tb_picoblaze_io_bridge.sv
// Self-checking bench for picoblaze_io_bridge (NUM_IN=4, NUM_OUT=4, INT_PERIOD=16).
module tb_picoblaze_io_bridge;

    localparam int NUM_IN     = 4;
    localparam int NUM_OUT    = 4;
    localparam int INT_PERIOD = 16;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [7:0]           port_id;
    logic [7:0]           out_port;
    logic                 write_strobe;
    logic                 read_strobe;
    logic [7:0]           in_port;
    logic                 interrupt;
    logic                 interrupt_ack;
    logic [NUM_IN*8-1:0]  in_data;
    logic                 start_pico;
    logic [NUM_OUT*8-1:0] out_data;
    logic [NUM_OUT-1:0]   out_wr_stb;
    logic                 pico_done;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    // Reference model state
    logic [7:0] m_out [NUM_OUT];
    logic       m_start;
    logic       m_ovr;
    logic       m_int_en;
    logic [7:0] m_cnt;

    always #5 clk = ~clk;

    picoblaze_io_bridge #(
        .NUM_IN     (NUM_IN),
        .NUM_OUT    (NUM_OUT),
        .INT_PERIOD (INT_PERIOD)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .port_id       (port_id),
        .out_port      (out_port),
        .write_strobe  (write_strobe),
        .read_strobe   (read_strobe),
        .in_port       (in_port),
        .interrupt     (interrupt),
        .interrupt_ack (interrupt_ack),
        .in_data       (in_data),
        .start_pico    (start_pico),
        .out_data      (out_data),
        .out_wr_stb    (out_wr_stb),
        .pico_done     (pico_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            fail_cnt++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [7:0] pid, output logic [7:0] val);
        port_id     = pid;
        read_strobe = 1'b1;
        cyc();
        read_strobe = 1'b0;
        val         = in_port;
    endtask

    task automatic do_write(input logic [7:0] pid, input logic [7:0] data);
        port_id      = pid;
        out_port     = data;
        write_strobe = 1'b1;
        cyc();
        write_strobe = 1'b0;
    endtask

    function automatic logic [31:0] exp_out_vec();
        logic [31:0] v;
        v = 32'h0;
        for (int i = 0; i < NUM_OUT; i++) v[i*8 +: 8] = m_out[i];
        return v;
    endfunction

    function automatic logic [7:0] exp_read(input logic [7:0] pid);
        int p;
        p = int'(pid);
        if (p < NUM_IN) return in_data[p*8 +: 8];
        if (pid == 8'h08) return {5'b00000, m_int_en, m_ovr, m_start};
        if (pid == 8'h09) return m_cnt;
        return 8'h00;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_OUT; i++) m_out[i] = 8'h00;
        m_start  = 1'b0;
        m_ovr    = 1'b0;
        m_int_en = 1'b0;
        m_cnt    = 8'h00;
    endtask

    initial begin
        logic [7:0]  rv;
        logic [7:0]  pid;
        logic [7:0]  data;
        logic [3:0]  exp_stb;
        int          n;
        int          d;
        int          hits;

        reset = 1'b1; port_id = 8'h00; out_port = 8'h00; write_strobe = 1'b0;
        read_strobe = 1'b0; interrupt_ack = 1'b0; in_data = '0; start_pico = 1'b0;
        model_reset();
        repeat (3) cyc();
        check("rst_in_port", {24'h0, in_port}, 32'h0);
        check("rst_interrupt", {31'h0, interrupt}, 32'h0);
        check("rst_out_data", out_data, 32'h0);
        check("rst_out_wr_stb", {28'h0, out_wr_stb}, 32'h0);
        check("rst_pico_done", {31'h0, pico_done}, 32'h0);
        reset = 1'b0;

        hits = 0;
        for (int i = 0; i < 3 * INT_PERIOD; i++) begin
            cyc();
            if (interrupt) hits++;
        end
        check("idle_no_interrupt", hits, 0);

        hits = 0;
        for (int i = 0; i < 256; i++) begin
            do_read(8'(i), rv);
            if (rv !== 8'h00 || out_data !== '0 || out_wr_stb !== '0 || pico_done !== 1'b0) hits++;
        end
        check("rst_read_all_ports", hits, 0);

        // Directed reads
        in_data[23:16] = 8'hA5;
        do_read(8'h02, rv);
        check("read_in2", {24'h0, rv}, 32'hA5);
        in_data[31:24] = 8'h5A;
        do_read(8'h07, rv);
        check("read_unmapped_07", {24'h0, rv}, 32'h0);
        do_read(8'h03, rv);
        check("read_in3", {24'h0, rv}, 32'h5A);

        // Directed writes
        do_write(8'h81, 8'h3C);
        m_out[1] = 8'h3C;
        check("wr81_data", out_data, exp_out_vec());
        check("wr81_stb", {28'h0, out_wr_stb}, 32'h2);
        cyc();
        check("wr81_stb_clear", {28'h0, out_wr_stb}, 32'h0);
        check("wr81_data_hold", out_data, exp_out_vec());
        do_write(8'h40, 8'h01);
        check("done_pulse", {31'h0, pico_done}, 32'h1);
        cyc();
        check("done_single", {31'h0, pico_done}, 32'h0);
        do_write(8'h40, 8'h00);
        check("done_none", {31'h0, pico_done}, 32'h0);
        do_write(8'h84, 8'hEE);
        check("wr_unmapped_data", out_data, exp_out_vec());
        check("wr_unmapped_stb", {28'h0, out_wr_stb}, 32'h0);

        // Start flag: set coincides with a clearing status read
        start_pico = 1'b1;
        cyc();
        do_read(8'h08, rv);
        check("start_same_edge_old", {24'h0, rv}, 32'h0);
        m_start = 1'b1;
        do_read(8'h08, rv);
        check("start_flag_set", {24'h0, rv}, {24'h0, exp_read(8'h08)});
        m_start = 1'b0;
        do_read(8'h08, rv);
        check("start_flag_cleared", {24'h0, rv}, {24'h0, exp_read(8'h08)});
        start_pico = 1'b0;
        repeat (3) cyc();

        // Randomized read/write traffic against the model
        for (int it = 0; it < 60; it++) begin
            in_data = $urandom;
            if ($urandom_range(0, 1) == 0) begin
                case ($urandom_range(0, 3))
                    0:       pid = 8'($urandom_range(0, 7));
                    1:       pid = 8'($urandom_range(8, 9));
                    2:       pid = 8'($urandom_range(0, 255));
                    default: pid = 8'($urandom_range(0, NUM_IN - 1));
                endcase
                do_read(pid, rv);
                check($sformatf("rand_read_%02h", pid), {24'h0, rv}, {24'h0, exp_read(pid)});
            end else begin
                case ($urandom_range(0, 2))
                    0:       pid = 8'h80 + 8'($urandom_range(0, 7));
                    1:       pid = 8'h40;
                    default: pid = 8'($urandom_range(0, 255));
                endcase
                if (pid == 8'h41) pid = 8'h42;
                data = 8'($urandom);
                do_write(pid, data);
                exp_stb = 4'h0;
                if (pid >= 8'h80 && int'(pid) < 8'h80 + NUM_OUT) begin
                    m_out[int'(pid) - 8'h80] = data;
                    exp_stb[int'(pid) - 8'h80] = 1'b1;
                end
                check($sformatf("rand_wr_data_%02h", pid), out_data, exp_out_vec());
                check($sformatf("rand_wr_stb_%02h", pid), {28'h0, out_wr_stb}, {28'h0, exp_stb});
                check($sformatf("rand_wr_done_%02h", pid), {31'h0, pico_done},
                      {31'h0, (pid == 8'h40) && data[0]});
            end
        end

        // Interrupt period with prompt acknowledge
        do_write(8'h41, 8'h01);
        m_int_en = 1'b1;
        n = 0;
        while (!interrupt && n < 3 * INT_PERIOD) begin
            cyc();
            n++;
        end
        check("first_tick_latency", n, INT_PERIOD);
        for (int k = 0; k < 3; k++) begin
            d = $urandom_range(1, 4);
            repeat (d - 1) cyc();
            interrupt_ack = 1'b1;
            cyc();
            interrupt_ack = 1'b0;
            check("ack_clears_irq", {31'h0, interrupt}, 32'h0);
            n = d;
            while (!interrupt && n < 3 * INT_PERIOD) begin
                cyc();
                n++;
            end
            check("irq_period", n, INT_PERIOD);
        end
        interrupt_ack = 1'b1;
        cyc();
        interrupt_ack = 1'b0;
        do_read(8'h08, rv);
        check("status_no_overrun", {24'h0, rv}, {24'h0, exp_read(8'h08)});

        // Withhold acknowledge across 300 ticks
        repeat (300 * INT_PERIOD) cyc();
        m_ovr = 1'b1;
`ifdef INT_OVERRUN_COUNT_EN
        m_cnt = 8'hFF;
`endif
        check("irq_held_overrun", {31'h0, interrupt}, 32'h1);
        do_write(8'h41, 8'h00);
        m_int_en = 1'b0;
        repeat (2 * INT_PERIOD) cyc();
        check("irq_pending_after_disable", {31'h0, interrupt}, 32'h1);
        do_read(8'h08, rv);
        check("status_overrun", {24'h0, rv}, {24'h0, exp_read(8'h08)});
        m_ovr = 1'b0;
        do_read(8'h09, rv);
        check("ovr_cnt_read", {24'h0, rv}, {24'h0, exp_read(8'h09)});
        m_cnt = 8'h00;
        do_read(8'h09, rv);
        check("ovr_cnt_cleared", {24'h0, rv}, {24'h0, exp_read(8'h09)});
        do_read(8'h08, rv);
        check("status_overrun_cleared", {24'h0, rv}, {24'h0, exp_read(8'h08)});
        interrupt_ack = 1'b1;
        cyc();
        interrupt_ack = 1'b0;
        check("final_ack", {31'h0, interrupt}, 32'h0);

        // Reset in the middle of operation
        do_write(8'h82, 8'h77);
        m_out[2] = 8'h77;
        check("pre_reset_data", out_data, exp_out_vec());
        do_write(8'h41, 8'h01);
        n = 0;
        while (!interrupt && n < 3 * INT_PERIOD) begin
            cyc();
            n++;
        end
        check("pre_reset_irq", {31'h0, interrupt}, 32'h1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        model_reset();
        check("midrst_interrupt", {31'h0, interrupt}, 32'h0);
        check("midrst_out_data", out_data, exp_out_vec());
        check("midrst_in_port", {24'h0, in_port}, 32'h0);
        do_read(8'h08, rv);
        check("midrst_status", {24'h0, rv}, {24'h0, exp_read(8'h08)});
        hits = 0;
        for (int i = 0; i < 3 * INT_PERIOD; i++) begin
            cyc();
            if (interrupt) hits++;
        end
        check("midrst_no_interrupt", hits, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/picoblaze_io_bridge.md
# picoblaze_io_bridge

Parametrised I/O bridge between a `pacoblaze3` core and the speech-synthesizer fabric. It provides:

- full 8-bit port decode for NUM_IN input ports and NUM_OUT registered output channels;
- a start/done handshake;
- a programmable periodic interrupt with a correct request/acknowledge handshake and overrun detection.

It replaces hand-written per-design port logic and the free-running interrupt toggle around the core.

## Interface
Parameters:
- `NUM_IN`, 4 — number of 8-bit input ports, 1..8.
- `NUM_OUT`, 4 — number of 8-bit output channels, 1..8.
- `INT_PERIOD`, 7200 — clk cycles between interrupt ticks, ≥2; counter width is `$clog2(INT_PERIOD)`.

Ports:
- `clk` input 1 — single clock; all logic on rising edge.
- `reset` input 1 — synchronous, active-high.
- `port_id` input 8 — from core.
- `out_port` input 8 — from core.
- `write_strobe` input 1 — from core.
- `read_strobe` input 1 — from core.
- `in_port` output 8 — to core, registered.
- `interrupt` output 1 — to core.
- `interrupt_ack` input 1 — from core.
- `in_data` input NUM_IN*8 — fabric inputs; port i is `[8i+7:8i]`.
- `start_pico` input 1 — level request from fabric.
- `out_data` output NUM_OUT*8 — output channel registers.
- `out_wr_stb` output NUM_OUT — one-cycle pulse per channel write.
- `pico_done` output 1 — one-cycle done pulse.

## Operation
Port map (exact 8-bit match; unmapped reads return 0x00, unmapped writes are ignored):
- Read `0x00+i` (i < NUM_IN): `in_data[i]`.
- Read `0x08`: status register.
  - bit0 start_flag, bit1 int_overrun, bit2 int_en, bits 7:3 = 0.
  - The read clears start_flag and int_overrun.
- Read `0x09`: overrun count (only with `INT_OVERRUN_COUNT_EN`, otherwise 0x00).
- Write `0x80+i` (i < NUM_OUT): `out_data[i] <= out_port`; `out_wr_stb[i]` pulses.
- Write `0x40`: if `out_port[0]`, pulse `pico_done`.
- Write `0x41`: `int_en <= out_port[0]`.

Start flag:
- `start_pico` is registered once; a rising edge of the registered copy sets start_flag.
- If a set and a status-read clear occur in the same cycle, set wins.

Interrupt timer:
- While int_en=1, the counter counts 0..INT_PERIOD-1 and wraps. A tick occurs at terminal count.
- Tick with interrupt=0: `interrupt <= 1`.
- Tick with interrupt=1 and no ack: int_overrun <= 1 and the overrun count increments.
- Tick and `interrupt_ack` in the same cycle: interrupt stays 1; no overrun.
- `interrupt_ack` alone: `interrupt <= 0`.
- int_en=0: counter is held at 0. A pending interrupt stays asserted until acked.

Overrun count: 8 bits, saturates at 0xFF, cleared by a read of `0x09`.

## Timing
- Reset values: `in_port`=0x00, `interrupt`=0, `out_data`=all 0, `out_wr_stb`=0, `pico_done`=0. Internal state also resets: start_flag=0, int_overrun=0, int_en=0, counter=0, overrun count=0.
- Reset asserted mid-operation aborts any pending interrupt.
- `in_port` is valid 1 cycle after `port_id` (registered mux).
- Read side effects act on the cycle where `read_strobe`=1.
- `out_data[i]`, `out_wr_stb[i]` and `pico_done` update 1 cycle after the `write_strobe` cycle.
- The interrupt rises 1 cycle after terminal count.
- With int_en set at cycle t, the first tick is at t+INT_PERIOD.
- Interrupt clears the cycle after `interrupt_ack`.

## Configuration
- `INT_OVERRUN_COUNT_EN` defined: the 8-bit saturating overrun counter exists, readable at `0x09`.
- Not defined: the counter is not instantiated; `0x09` reads 0x00. The int_overrun status bit is always present.

## Structure
- Shared package `picoblaze_io_pkg` holds:
  - port address constants: `PORT_IN_BASE`, `PORT_STATUS`, `PORT_OVR_CNT`, `PORT_OUT_BASE`, `PORT_DONE`, `PORT_INT_CTRL`;
  - status bit index constants.
- One sub-module, `picoblaze_int_timer`, contains:
  - the period counter, interrupt request/ack flop and overrun logic;
  - the optional overrun counter.
- Decode, the start flag and the output registers live in the top level.

## Test plan
- Reset, then read every port → `in_port`=0x00, all outputs 0, no interrupt for 3×INT_PERIOD.
- `in_data[2]`=0xA5, read `0x02` → `in_port`=0xA5 one cycle later. Read `0x07` with NUM_IN=4 → 0x00.
- Write 0x3C to `0x81` → `out_data[1]`=0x3C, `out_wr_stb`=4'b0010 for exactly 1 cycle. Write `0x40` with 0x01 → one `pico_done` pulse; with 0x00 → none.
- `start_pico` 0→1 with a status read on the same edge → status bit0 stays 1. The next read returns bit0=1; the following read returns 0.
- INT_PERIOD=16, write 0x01 to `0x41`, ack within 5 cycles → interrupt period is exactly 16 cycles, status bit1=0.
- Withhold ack across 300 ticks → status bit1=1. With the macro, `0x09` reads 0xFF (saturated), then 0x00 on the next read.
